mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  MEM pipeline stage. Sits between the exe_mem register and the mem_wb register.
//  Non-memory ops pass through unchanged. Loads and stores run a request/grant/response
//  handshake on the data bus; the stage stalls the pipeline until the response arrives.
//  Also handles byte-lane steering, byte enables, load sign/zero extension and misalignment.
// PARAMETERS
//  DATA_WIDTH   32  data bus / register width (only 32 supported)
//  ADDR_WIDTH   32  byte address width
//  RADDR_WIDTH  5   register-file address width
// PORTS
//  clk_i          in   1    clock; one clock domain
//  rst_i          in   1    asynchronous, active-high reset
//  reg_waddr_i    in   5    rd from exe_mem
//  reg_we_i       in   1    rd write enable from exe_mem
//  reg_wdata_i    in   32   ALU result from exe_mem
//  mem_we_i       in   1    store flag (informational; mem_op_i is authoritative)
//  mem_addr_i     in   32   byte address
//  mem_data_i     in   32   store data (rs2, unaligned in low bits)
//  mem_op_i       in   4    MEM_NOP=0 LB=1 LH=2 LW=3 LBU=4 LHU=5 SB=6 SH=7 SW=8
//  dbus_req_o     out  1    bus request
//  dbus_we_o      out  1    1 = write
//  dbus_addr_o    out  32   word-aligned address: {mem_addr_i[31:2],2'b00}
//  dbus_wdata_o   out  32   lane-replicated store data
//  dbus_be_o      out  4    byte enables
//  dbus_gnt_i     in   1    request accepted
//  dbus_rvalid_i  in   1    response (read data or write ack)
//  dbus_rdata_i   in   32   read data
//  reg_waddr_o    out  5    to mem_wb
//  reg_we_o       out  1    to mem_wb
//  reg_wdata_o    out  32   to mem_wb
//  stallreq_o     out  1    to pipe_ctrl; 1 = hold the pipeline
//  misalign_o     out  1    misaligned access detected this cycle
// BEHAVIOUR
//  Reset: state IDLE, rdata_q = 0. While rst_i = 1, every output is 0.
//  Definitions:
//   act = (mem_op_i != NOP) & !mis
//   mis = (LH|LHU|SH) & addr[0]  |  (LW|SW) & (addr[1:0] != 0)
//  FSM states: IDLE, REQ, WAIT, DONE.
//   IDLE: dbus_req_o = act.
//     act & gnt  -> WAIT
//     act & !gnt -> REQ
//     otherwise  -> stay IDLE
//   REQ: dbus_req_o = 1; stay until gnt, then -> WAIT.
//     addr/we/wdata/be are held stable while req is asserted.
//   WAIT: dbus_req_o = 0. On rvalid: rdata_q <= dbus_rdata_i, -> DONE.
//   DONE: no request; outputs use rdata_q. -> IDLE on the next cycle.
//     The pipeline advances in this cycle, so the same op is never reissued.
//  rvalid arriving in IDLE or REQ is ignored.
//  Only one transaction is ever outstanding.
//  stallreq_o = act & (state != DONE).
//   Minimum stall is 2 cycles (gnt in cycle 0, rvalid in cycle 1, DONE in cycle 2).
//  Store lanes:
//   SB: wdata = {4{d[7:0]}},  be = 4'b0001 << addr[1:0]
//   SH: wdata = {2{d[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011
//   SW: wdata = d,            be = 4'b1111
//  Load result (valid in DONE only): select byte by addr[1:0], half by addr[1].
//   LB/LH sign-extend; LBU/LHU zero-extend; LW uses the whole word.
//  Outputs to mem_wb:
//   Loads: reg_wdata_o = extended result in DONE, else 0.
//   Stores: reg_we_o = 0.
//   NOP: reg_* = reg_*_i, combinational, no stall.
//  Misaligned op: misalign_o = 1, no bus request, no stall, reg_we_o = 0.
//  Reset mid-transaction: drops to IDLE and deasserts req immediately.
//   A late rvalid after reset is ignored.
// STRUCTURE
//  defines.v holds the MEM_* op codes and the FSM state encodings (2-bit).
//  Sub-module mem_align (combinational): detects misalignment, builds store wdata/be,
//   and does load extraction and extension. mem_access holds the FSM and muxes.
// TESTING
//  1. NOP, reg_wdata_i=0x1234, we=1 -> same cycle reg_wdata_o=0x1234, stallreq_o=0, no req.
//  2. LW addr=0x100, gnt same cycle, rvalid+rdata=0xDEADBEEF next cycle
//     -> stall 2 cycles, then reg_wdata_o=0xDEADBEEF, reg_we_o=1.
//  3. LB addr=0x103, rdata=0x80FF_0000 -> 0xFFFFFF80;
//     LBU -> 0x00000080; LHU addr=0x102 -> 0x000080FF.
//  4. SB addr=0x201 data=0xAB, gnt held low 3 cycles
//     -> req held, be=0010, wdata=0xABABABAB stable; done after ack.
//  5. LH addr=0x101 -> misalign_o=1, dbus_req_o=0, stallreq_o=0, reg_we_o=0.
//  6. rst_i pulsed in WAIT, then late rvalid -> outputs 0, state IDLE, rvalid ignored.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: op codes, FSM states
// and bus geometry.
package mem_access_pkg;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int RAW = 5;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_st_e;

endpackage

// File: rtl/mem_access_align.sv
// Combinational lane logic: misalignment, store steering/byte
// enables, load byte/half extraction with sign/zero extension.
// Ports: i_op, i_addr(1:0), i_sdata, i_rdata -> o_mis, o_load,
//        o_store, o_wdata, o_be, o_ldata.
module mem_access_align
  import mem_access_pkg::*;
(
  input  logic [3:0]    i_op,
  input  logic [1:0]    i_addr,
  input  logic [DW-1:0] i_sdata,
  input  logic [DW-1:0] i_rdata,
  output logic          o_mis,
  output logic          o_load,
  output logic          o_store,
  output logic [DW-1:0] o_wdata,
  output logic [3:0]    o_be,
  output logic [DW-1:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_addr[1]
    ? (i_addr[0] ? i_rdata[31:24] : i_rdata[23:16])
    : (i_addr[0] ? i_rdata[15:8]  : i_rdata[7:0]);
  assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_mis   = 1'b0;
    o_load  = 1'b0;
    o_store = 1'b0;
    o_wdata = '0;
    o_be    = 4'b0000;
    o_ldata = '0;
    case (mem_op_e'(i_op))
      MEM_LB: begin
        o_load  = 1'b1;
        o_ldata = {{24{w_byte[7]}}, w_byte};
      end
      MEM_LBU: begin
        o_load  = 1'b1;
        o_ldata = {24'd0, w_byte};
      end
      MEM_LH: begin
        o_load  = 1'b1;
        o_mis   = i_addr[0];
        o_ldata = {{16{w_half[15]}}, w_half};
      end
      MEM_LHU: begin
        o_load  = 1'b1;
        o_mis   = i_addr[0];
        o_ldata = {16'd0, w_half};
      end
      MEM_LW: begin
        o_load  = 1'b1;
        o_mis   = |i_addr;
        o_ldata = i_rdata;
      end
      MEM_SB: begin
        o_store = 1'b1;
        o_wdata = {4{i_sdata[7:0]}};
        o_be    = 4'b0001 << i_addr;
      end
      MEM_SH: begin
        o_store = 1'b1;
        o_mis   = i_addr[0];
        o_wdata = {2{i_sdata[15:0]}};
        o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
      end
      MEM_SW: begin
        o_store = 1'b1;
        o_mis   = |i_addr;
        o_wdata = i_sdata;
        o_be    = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: passes non-memory ops through, runs a req/gnt/rvalid
// bus handshake for loads/stores and stalls until the response.
// Ports: exe_mem inputs (reg_*_i, mem_*_i), data bus (dbus_*),
//        mem_wb outputs (reg_*_o), stallreq_o, misalign_o.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
  input  logic                   mem_we_i,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  input  logic [3:0]             mem_op_i,
  output logic                   dbus_req_o,
  output logic                   dbus_we_o,
  output logic [ADDR_WIDTH-1:0]  dbus_addr_o,
  output logic [DATA_WIDTH-1:0]  dbus_wdata_o,
  output logic [3:0]             dbus_be_o,
  input  logic                   dbus_gnt_i,
  input  logic                   dbus_rvalid_i,
  input  logic [DATA_WIDTH-1:0]  dbus_rdata_i,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [DATA_WIDTH-1:0]  reg_wdata_o,
  output logic                   stallreq_o,
  output logic                   misalign_o
);

  mem_st_e         r_state;
  mem_st_e         w_next;
  logic [DW-1:0]   r_rdata;
  logic            w_mis;
  logic            w_load;
  logic            w_store;
  logic            w_nop;
  logic            w_act;
  logic [DW-1:0]   w_wdata;
  logic [3:0]      w_be;
  logic [DW-1:0]   w_ldata;
  logic            w_unused_we;

  // mem_op_i alone decides read vs write
  assign w_unused_we = mem_we_i;

  mem_access_align u_align (
    .i_op    (mem_op_i),
    .i_addr  (mem_addr_i[1:0]),
    .i_sdata (mem_data_i),
    .i_rdata (r_rdata),
    .o_mis   (w_mis),
    .o_load  (w_load),
    .o_store (w_store),
    .o_wdata (w_wdata),
    .o_be    (w_be),
    .o_ldata (w_ldata)
  );

  assign w_nop = (mem_op_i == MEM_NOP);
  assign w_act = (w_load | w_store) & !w_mis;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_WAIT && dbus_rvalid_i)
        r_rdata <= dbus_rdata_i;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:
        if (w_act)
          w_next = dbus_gnt_i ? ST_WAIT : ST_REQ;
      ST_REQ:
        if (dbus_gnt_i) w_next = ST_WAIT;
      ST_WAIT:
        if (dbus_rvalid_i) w_next = ST_DONE;
      ST_DONE:
        w_next = ST_IDLE;
      default:
        w_next = ST_IDLE;
    endcase
  end

  // Everything is forced low while reset is held
  always_comb begin
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = '0;
    dbus_wdata_o = '0;
    dbus_be_o    = 4'b0000;
    reg_waddr_o  = '0;
    reg_we_o     = 1'b0;
    reg_wdata_o  = '0;
    stallreq_o   = 1'b0;
    misalign_o   = 1'b0;
    if (!rst_i) begin
      misalign_o  = w_mis;
      reg_waddr_o = reg_waddr_i;
      stallreq_o  = w_act & (r_state != ST_DONE);
      if (w_act) begin
        dbus_req_o = (r_state == ST_IDLE) ||
                     (r_state == ST_REQ);
        dbus_we_o    = w_store;
        dbus_addr_o  = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
        dbus_wdata_o = w_wdata;
        dbus_be_o    = w_be;
      end
      if (w_nop) begin
        reg_we_o    = reg_we_i;
        reg_wdata_o = reg_wdata_i;
      end else if (w_act && w_load &&
                   r_state == ST_DONE) begin
        reg_we_o    = reg_we_i;
        reg_wdata_o = w_ldata;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for the MEM stage: passthrough, loads, stores
// with delayed grant, misalignment and reset mid-transaction.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic [31:0] reg_wdata_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [3:0]  mem_op_i;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [31:0] dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_gnt_i;
  logic        dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [31:0] reg_wdata_o;
  logic        stallreq_o;
  logic        misalign_o;

  int errs = 0;
  int chks = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .reg_waddr_i   (reg_waddr_i),
    .reg_we_i      (reg_we_i),
    .reg_wdata_i   (reg_wdata_i),
    .mem_we_i      (mem_we_i),
    .mem_addr_i    (mem_addr_i),
    .mem_data_i    (mem_data_i),
    .mem_op_i      (mem_op_i),
    .dbus_req_o    (dbus_req_o),
    .dbus_we_o     (dbus_we_o),
    .dbus_addr_o   (dbus_addr_o),
    .dbus_wdata_o  (dbus_wdata_o),
    .dbus_be_o     (dbus_be_o),
    .dbus_gnt_i    (dbus_gnt_i),
    .dbus_rvalid_i (dbus_rvalid_i),
    .dbus_rdata_i  (dbus_rdata_i),
    .reg_waddr_o   (reg_waddr_o),
    .reg_we_o      (reg_we_o),
    .reg_wdata_o   (reg_wdata_o),
    .stallreq_o    (stallreq_o),
    .misalign_o    (misalign_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_op(input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] d);
    mem_op_i   = op;
    mem_addr_i = a;
    mem_data_i = d;
    mem_we_i   = (op >= 4'd6);
  endtask

  // Zero-wait load: gnt in cycle 0, rvalid in cycle 1
  task automatic do_load(input string tag,
                         input logic [3:0] op,
                         input logic [31:0] a,
                         input logic [31:0] rd,
                         input logic [31:0] exp);
    set_op(op, a, 32'h0);
    reg_we_i      = 1'b1;
    reg_waddr_i   = 5'd7;
    dbus_gnt_i    = 1'b1;
    dbus_rvalid_i = 1'b0;
    smp();
    chk({tag, ".req0"}, 32'(dbus_req_o), 32'd1);
    chk({tag, ".stl0"}, 32'(stallreq_o), 32'd1);
    chk({tag, ".adr"}, dbus_addr_o, {a[31:2], 2'b00});
    nxt();
    dbus_gnt_i    = 1'b0;
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = rd;
    smp();
    chk({tag, ".req1"}, 32'(dbus_req_o), 32'd0);
    chk({tag, ".stl1"}, 32'(stallreq_o), 32'd1);
    nxt();
    dbus_rvalid_i = 1'b0;
    dbus_rdata_i  = 32'h0;
    smp();
    chk({tag, ".stl2"}, 32'(stallreq_o), 32'd0);
    chk({tag, ".we"}, 32'(reg_we_o), 32'd1);
    chk({tag, ".dat"}, reg_wdata_o, exp);
    nxt();
    set_op(4'd0, 32'h0, 32'h0);
  endtask

  initial begin
    rst           = 1'b1;
    reg_waddr_i   = 5'd3;
    reg_we_i      = 1'b1;
    reg_wdata_i   = 32'h1234;
    dbus_gnt_i    = 1'b0;
    dbus_rvalid_i = 1'b0;
    dbus_rdata_i  = 32'h0;
    set_op(4'd0, 32'h0, 32'h0);
    smp();
    chk("rst.we", 32'(reg_we_o), 32'd0);
    chk("rst.dat", reg_wdata_o, 32'd0);
    chk("rst.wa", 32'(reg_waddr_o), 32'd0);
    nxt();
    rst = 1'b0;

    // NOP passthrough
    smp();
    chk("nop.dat", reg_wdata_o, 32'h1234);
    chk("nop.we", 32'(reg_we_o), 32'd1);
    chk("nop.wa", 32'(reg_waddr_o), 32'd3);
    chk("nop.stl", 32'(stallreq_o), 32'd0);
    chk("nop.req", 32'(dbus_req_o), 32'd0);
    nxt();

    do_load("lw", 4'd3, 32'h100, 32'hDEADBEEF,
            32'hDEADBEEF);
    do_load("lb", 4'd1, 32'h103, 32'h80FF_0000,
            32'hFFFF_FF80);
    do_load("lbu", 4'd4, 32'h103, 32'h80FF_0000,
            32'h0000_0080);
    do_load("lhu", 4'd5, 32'h102, 32'h80FF_0000,
            32'h0000_80FF);
    do_load("lh", 4'd2, 32'h102, 32'h80FF_0000,
            32'hFFFF_80FF);
    do_load("lb0", 4'd1, 32'h100, 32'h0000_007F,
            32'h0000_007F);

    // SB with grant held off for 3 cycles
    set_op(4'd6, 32'h201, 32'hAB);
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("sb.req", 32'(dbus_req_o), 32'd1);
      chk("sb.we", 32'(dbus_we_o), 32'd1);
      chk("sb.be", 32'(dbus_be_o), 32'h2);
      chk("sb.wd", dbus_wdata_o, 32'hABABABAB);
      chk("sb.adr", dbus_addr_o, 32'h200);
      chk("sb.stl", 32'(stallreq_o), 32'd1);
      nxt();
    end
    dbus_gnt_i = 1'b1;
    smp();
    chk("sb.reqg", 32'(dbus_req_o), 32'd1);
    nxt();
    dbus_gnt_i    = 1'b0;
    dbus_rvalid_i = 1'b1;
    smp();
    chk("sb.wreq", 32'(dbus_req_o), 32'd0);
    chk("sb.wstl", 32'(stallreq_o), 32'd1);
    nxt();
    dbus_rvalid_i = 1'b0;
    smp();
    chk("sb.dstl", 32'(stallreq_o), 32'd0);
    chk("sb.rwe", 32'(reg_we_o), 32'd0);
    nxt();

    // SH upper half and SW lanes, checked in the request cycle
    set_op(4'd7, 32'h302, 32'h5566_BEEF);
    smp();
    chk("sh.be", 32'(dbus_be_o), 32'hC);
    chk("sh.wd", dbus_wdata_o, 32'hBEEFBEEF);
    set_op(4'd8, 32'h300, 32'h1122_3344);
    smp();
    chk("sw.be", 32'(dbus_be_o), 32'hF);
    chk("sw.wd", dbus_wdata_o, 32'h11223344);
    nxt();
    set_op(4'd0, 32'h0, 32'h0);
    nxt();

    // Misaligned LH and SW
    set_op(4'd2, 32'h101, 32'h0);
    smp();
    chk("mis.flag", 32'(misalign_o), 32'd1);
    chk("mis.req", 32'(dbus_req_o), 32'd0);
    chk("mis.stl", 32'(stallreq_o), 32'd0);
    chk("mis.we", 32'(reg_we_o), 32'd0);
    set_op(4'd8, 32'h102, 32'h0);
    smp();
    chk("misw.flag", 32'(misalign_o), 32'd1);
    chk("misw.req", 32'(dbus_req_o), 32'd0);
    set_op(4'd1, 32'h103, 32'h0);
    smp();
    chk("lbodd.mis", 32'(misalign_o), 32'd0);
    nxt();
    set_op(4'd0, 32'h0, 32'h0);
    nxt();

    // Reset while in WAIT, then late rvalid
    set_op(4'd3, 32'h400, 32'h0);
    dbus_gnt_i = 1'b1;
    nxt();
    dbus_gnt_i = 1'b0;
    rst = 1'b1;
    smp();
    chk("rw.req", 32'(dbus_req_o), 32'd0);
    chk("rw.stl", 32'(stallreq_o), 32'd0);
    chk("rw.adr", dbus_addr_o, 32'd0);
    chk("rw.wa", 32'(reg_waddr_o), 32'd0);
    nxt();
    rst           = 1'b0;
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = 32'hBAD0BAD0;
    smp();
    chk("late.req0", 32'(dbus_req_o), 32'd1);
    chk("late.stl0", 32'(stallreq_o), 32'd1);
    nxt();
    smp();
    chk("late.req1", 32'(dbus_req_o), 32'd1);
    chk("late.stl1", 32'(stallreq_o), 32'd1);
    dbus_gnt_i = 1'b1;
    dbus_rvalid_i = 1'b0;
    nxt();
    dbus_gnt_i    = 1'b0;
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = 32'h0000_5A5A;
    nxt();
    dbus_rvalid_i = 1'b0;
    smp();
    chk("late.stl", 32'(stallreq_o), 32'd0);
    chk("late.dat", reg_wdata_o, 32'h0000_5A5A);
    nxt();
    set_op(4'd0, 32'h0, 32'h0);
    nxt();

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
